// File: rtl/exception_controller_pkg.sv
// Shared types and cause codes for the exception/interrupt sequencer.
package exceptionGroup;

   typedef enum logic [2:0] {IDLE, PENDING, ENTRY, SERVICE, HALT} state_e;

   localparam logic [4:0] CAUSE_NONE     = 5'd0;
   localparam logic [4:0] CAUSE_ILLEGAL  = 5'd1;
   localparam logic [4:0] CAUSE_MISALIGN = 5'd2;
   localparam logic [4:0] CAUSE_SYSCALL  = 5'd3;
   localparam logic [4:0] CAUSE_DIVZERO  = 5'd4;
   localparam logic [4:0] CAUSE_IRQ_BASE = 5'd16;

   // Fault causes occupy 1..nfault; everything above is an interrupt.
   function automatic logic is_fault_cause(input logic [4:0] c, input int nfault);
      return (c != CAUSE_NONE) && (int'(c) <= nfault);
   endfunction

endpackage

// File: rtl/exception_controller_if.sv
// Signals between the sequencer and the CPU control / system-register blocks.
interface exception_controller_if #(
   parameter int NUM_IRQ   = 16,
   parameter int NUM_FAULT = 4
);
   logic [NUM_IRQ-1:0]   irq;
   logic [NUM_FAULT-1:0] faultIn;
   logic                 interruptEnable;
   logic [NUM_IRQ-1:0]   exceptionMask;
   logic [31:0]          isrBaseAddress;
   logic [31:0]          pcIn;
   logic                 instrBoundary;
   logic                 eret;
   logic                 exceptionPending;
   logic [4:0]           cause;
   logic                 vectorValid;
   logic [31:0]          vectorAddress;
   logic                 interruptDisable;
   logic                 returnValid;
   logic [31:0]          returnAddress;
   logic                 interruptRestore;
   logic                 restoreValue;
   logic                 halted;

   modport master (
      output irq, faultIn, interruptEnable, exceptionMask, isrBaseAddress, pcIn,
             instrBoundary, eret,
      input  exceptionPending, cause, vectorValid, vectorAddress, interruptDisable,
             returnValid, returnAddress, interruptRestore, restoreValue, halted
   );

   modport slave (
      input  irq, faultIn, interruptEnable, exceptionMask, isrBaseAddress, pcIn,
             instrBoundary, eret,
      output exceptionPending, cause, vectorValid, vectorAddress, interruptDisable,
             returnValid, returnAddress, interruptRestore, restoreValue, halted
   );
endinterface

// File: rtl/exception_controller_priority_encoder.sv
// Fixed-priority arbitration: any fault beats any IRQ, lowest index wins in each group.
module exception_priority_encoder
   import exceptionGroup::*;
#(
   parameter int NUM_IRQ        = 16,
   parameter int NUM_FAULT      = 4,
   parameter int IRQ_CAUSE_BASE = 16
) (
   input  logic [NUM_FAULT-1:0] fault_i,
   input  logic [NUM_IRQ-1:0]   irq_i,
   output logic                 valid_o,
   output logic                 is_fault_o,
   output logic [4:0]           cause_o
);

   always_comb begin
      valid_o    = (|fault_i) | (|irq_i);
      is_fault_o = |fault_i;
      cause_o    = CAUSE_NONE;
      // Scan high to low so the lowest set index is the last write; faults overwrite IRQs.
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (irq_i[i]) cause_o = 5'(IRQ_CAUSE_BASE + i);
      for (int j = NUM_FAULT - 1; j >= 0; j--)
         if (fault_i[j]) cause_o = 5'(j + 1);
   end

endmodule

// File: rtl/exception_controller.sv
// Exception/interrupt sequencer: arbitration, entry handshake, vectoring, epc save and return.
module exception_controller
   import exceptionGroup::*;
#(
   parameter int NUM_IRQ        = 16,
   parameter int NUM_FAULT      = 4,
   parameter int IRQ_CAUSE_BASE = 16
) (
   input  logic            clk,
   input  logic            reset,
   exception_controller_if.slave bus
);

   state_e               state_q, state_d;
   logic [4:0]           cause_q, cause_d;
   logic [NUM_FAULT-1:0] fault_q, fault_d, fault_eff, fault_clr;
   logic [31:0]          epc_q;
   logic                 saved_ie_q;
   logic [NUM_IRQ-1:0]   irq_elig;
   logic                 enc_valid, enc_is_fault;
   logic [4:0]           enc_cause;

   assign irq_elig  = bus.irq & bus.exceptionMask & {NUM_IRQ{bus.interruptEnable}};
   // A pulse arriving this cycle already counts as latched for arbitration.
   assign fault_eff = fault_q | bus.faultIn;

   exception_priority_encoder #(
      .NUM_IRQ        (NUM_IRQ),
      .NUM_FAULT      (NUM_FAULT),
      .IRQ_CAUSE_BASE (IRQ_CAUSE_BASE)
   ) u_enc (
      .fault_i    (fault_eff),
      .irq_i      (irq_elig),
      .valid_o    (enc_valid),
      .is_fault_o (enc_is_fault),
      .cause_o    (enc_cause)
   );

   always_comb begin
      for (int j = 0; j < NUM_FAULT; j++)
         fault_clr[j] = (state_q == ENTRY) && (cause_q == 5'(j + 1));
   end
   assign fault_d = (fault_q & ~fault_clr) | bus.faultIn;

   always_comb begin
      state_d              = state_q;
      cause_d              = cause_q;
      bus.exceptionPending = 1'b0;
      bus.vectorValid      = 1'b0;
      bus.vectorAddress    = 32'h0;
      bus.interruptDisable = 1'b0;
      bus.returnValid      = 1'b0;
      bus.interruptRestore = 1'b0;
      bus.halted           = 1'b0;
      case (state_q)
         IDLE: begin
            if (enc_valid) begin
               cause_d = enc_cause;
               state_d = PENDING;
            end
         end
         PENDING: begin
            bus.exceptionPending = 1'b1;
            if (!is_fault_cause(cause_q, NUM_FAULT) && enc_is_fault) cause_d = enc_cause;
            if (bus.instrBoundary) state_d = ENTRY;
         end
         ENTRY: begin
            bus.exceptionPending = 1'b1;
            bus.vectorValid      = 1'b1;
            bus.interruptDisable = 1'b1;
            bus.vectorAddress    = bus.isrBaseAddress + {25'd0, cause_q, 2'b00};
            state_d              = SERVICE;
         end
         SERVICE: begin
            // A fault inside the handler is fatal and suppresses a coincident return.
            if (|bus.faultIn) begin
               state_d = HALT;
            end else if (bus.eret) begin
               bus.returnValid      = 1'b1;
               bus.interruptRestore = 1'b1;
               state_d              = IDLE;
            end
         end
         HALT: begin
            bus.exceptionPending = 1'b1;
            bus.halted           = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.cause         = cause_q;
   assign bus.returnAddress = epc_q;
   assign bus.restoreValue  = saved_ie_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cause_q    <= CAUSE_NONE;
         fault_q    <= '0;
         epc_q      <= 32'h0;
         saved_ie_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         fault_q <= fault_d;
         if (state_q == ENTRY) begin
            epc_q      <= bus.pcIn;
            saved_ie_q <= bus.interruptEnable;
         end
      end
   end

endmodule

// File: tb/tb_exception_controller.sv
// Directed scenarios plus a randomized run against a cycle-level behavioural model.
module tb_exception_controller;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   exception_controller_if #(.NUM_IRQ(16), .NUM_FAULT(4)) bus ();

   exception_controller #(.NUM_IRQ(16), .NUM_FAULT(4), .IRQ_CAUSE_BASE(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [75:0] obs;
   assign obs = {bus.exceptionPending, bus.cause, bus.vectorValid, bus.vectorAddress,
                 bus.interruptDisable, bus.returnValid, bus.returnAddress,
                 bus.interruptRestore, bus.restoreValue, bus.halted};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.irq             = '0;
      bus.faultIn         = '0;
      bus.interruptEnable = 1'b0;
      bus.exceptionMask   = '0;
      bus.isrBaseAddress  = 32'h1000;
      bus.pcIn            = 32'h0;
      bus.instrBoundary   = 1'b0;
      bus.eret            = 1'b0;
   endtask

   task automatic apply_reset();
      drive_idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      #1;
      reset = 1'b1;
      #1;
      tests++;
      if (obs !== 76'h0) begin fails++; $display("FAIL reset_async got %h want 0", obs); end
      tick();
      tick();
      tests++;
      if (obs !== 76'h0) begin fails++; $display("FAIL reset_held got %h want 0", obs); end
      reset = 1'b0;
   endtask

   task automatic test_irq_entry();
      apply_reset();
      bus.irq = 16'h0008; bus.exceptionMask = 16'h0008; bus.interruptEnable = 1'b1;
      bus.isrBaseAddress = 32'h1000; bus.pcIn = 32'h200;
      #1;
      tests++;
      if (bus.exceptionPending !== 1'b0) begin fails++; $display("FAIL irq_pre_pend got %b want 0", bus.exceptionPending); end
      tick();
      for (int k = 0; k < 3; k++) begin
         #1;
         tests++;
         if ({bus.exceptionPending, bus.cause, bus.vectorValid} !== {1'b1, 5'd19, 1'b0}) begin
            fails++; $display("FAIL irq_pending got %b/%0d/%b want 1/19/0", bus.exceptionPending, bus.cause, bus.vectorValid);
         end
         tick();
      end
      bus.instrBoundary = 1'b1;
      #1;
      tests++;
      if ({bus.exceptionPending, bus.vectorValid} !== 2'b10) begin fails++; $display("FAIL irq_boundary got %b%b want 10", bus.exceptionPending, bus.vectorValid); end
      tick();
      bus.instrBoundary = 1'b0;
      #1;
      tests++;
      if ({bus.exceptionPending, bus.vectorValid, bus.interruptDisable, bus.vectorAddress} !== {3'b111, 32'h104C}) begin
         fails++; $display("FAIL irq_entry got %b%b%b %h want 111 104c", bus.exceptionPending, bus.vectorValid, bus.interruptDisable, bus.vectorAddress);
      end
      tick();
      #1;
      tests++;
      if ({bus.exceptionPending, bus.vectorValid, bus.interruptDisable, bus.returnValid, bus.returnAddress} !== {4'b0000, 32'h200}) begin
         fails++; $display("FAIL irq_service got %b%b%b%b %h want 0000 200", bus.exceptionPending, bus.vectorValid, bus.interruptDisable, bus.returnValid, bus.returnAddress);
      end
      bus.eret = 1'b1; bus.irq = '0;
      #1;
      tests++;
      if ({bus.returnValid, bus.interruptRestore, bus.restoreValue, bus.returnAddress} !== {3'b111, 32'h200}) begin
         fails++; $display("FAIL eret_return got %b%b%b %h want 111 200", bus.returnValid, bus.interruptRestore, bus.restoreValue, bus.returnAddress);
      end
      tick();
      bus.eret = 1'b0;
      #1;
      tests++;
      if ({bus.returnValid, bus.exceptionPending, bus.cause} !== {2'b00, 5'd19}) begin
         fails++; $display("FAIL eret_idle got %b%b/%0d want 00/19", bus.returnValid, bus.exceptionPending, bus.cause);
      end
      tick();
   endtask

   task automatic test_masked();
      apply_reset();
      bus.irq = 16'h0020; bus.exceptionMask = 16'h0000; bus.interruptEnable = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k == 3) begin bus.exceptionMask = 16'h0020; bus.interruptEnable = 1'b0; end
         #1;
         tests++;
         if ({bus.exceptionPending, bus.cause} !== 6'd0) begin
            fails++; $display("FAIL masked_step%0d got %b/%0d want 0/0", k, bus.exceptionPending, bus.cause);
         end
         tick();
      end
      bus.interruptEnable = 1'b1;
      tick();
      tests++;
      if ({bus.exceptionPending, bus.cause} !== {1'b1, 5'd21}) begin
         fails++; $display("FAIL unmasked_take got %b/%0d want 1/21", bus.exceptionPending, bus.cause);
      end
   endtask

   task automatic test_fault_preempt();
      apply_reset();
      bus.irq = 16'h0004; bus.exceptionMask = 16'hFFFF; bus.interruptEnable = 1'b1;
      tick();
      bus.faultIn = 4'b0010;
      #1;
      tests++;
      if ({bus.exceptionPending, bus.cause} !== {1'b1, 5'd18}) begin fails++; $display("FAIL preempt_irq got %b/%0d want 1/18", bus.exceptionPending, bus.cause); end
      tick();
      bus.faultIn = 4'b0000; bus.instrBoundary = 1'b1;
      #1;
      tests++;
      if ({bus.exceptionPending, bus.cause} !== {1'b1, 5'd2}) begin fails++; $display("FAIL preempt_cause got %b/%0d want 1/2", bus.exceptionPending, bus.cause); end
      tick();
      bus.instrBoundary = 1'b0;
      #1;
      tests++;
      if ({bus.vectorValid, bus.vectorAddress} !== {1'b1, 32'h1008}) begin fails++; $display("FAIL preempt_vector got %b %h want 1 1008", bus.vectorValid, bus.vectorAddress); end
      tick();
      bus.eret = 1'b1;
      #1;
      tests++;
      if (bus.returnValid !== 1'b1) begin fails++; $display("FAIL preempt_eret got %b want 1", bus.returnValid); end
      tick();
      bus.eret = 1'b0;
      tick();
      // irq[2] is still high: a cleared latch means the IRQ, not fault 1, is taken now.
      tests++;
      if ({bus.exceptionPending, bus.cause} !== {1'b1, 5'd18}) begin fails++; $display("FAIL latch_cleared got %b/%0d want 1/18", bus.exceptionPending, bus.cause); end
   endtask

   task automatic test_dual_fault();
      apply_reset();
      bus.faultIn = 4'b0101;
      #1;
      tests++;
      if (bus.exceptionPending !== 1'b0) begin fails++; $display("FAIL dual_pre got %b want 0", bus.exceptionPending); end
      tick();
      bus.faultIn = 4'b0000; bus.instrBoundary = 1'b1;
      #1;
      tests++;
      if ({bus.exceptionPending, bus.cause} !== {1'b1, 5'd1}) begin fails++; $display("FAIL dual_first got %b/%0d want 1/1", bus.exceptionPending, bus.cause); end
      tick();
      bus.instrBoundary = 1'b0;
      #1;
      tests++;
      if ({bus.vectorValid, bus.vectorAddress} !== {1'b1, 32'h1004}) begin fails++; $display("FAIL dual_vector got %b %h want 1 1004", bus.vectorValid, bus.vectorAddress); end
      tick();
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      #1;
      tests++;
      if ({bus.exceptionPending, bus.returnValid} !== 2'b00) begin fails++; $display("FAIL dual_idle got %b%b want 00", bus.exceptionPending, bus.returnValid); end
      tick();
      tests++;
      if ({bus.exceptionPending, bus.cause} !== {1'b1, 5'd3}) begin fails++; $display("FAIL dual_second got %b/%0d want 1/3", bus.exceptionPending, bus.cause); end
   endtask

   task automatic test_double_fault();
      apply_reset();
      bus.irq = 16'h0001; bus.exceptionMask = 16'h0001; bus.interruptEnable = 1'b1; bus.pcIn = 32'h300;
      tick();
      bus.instrBoundary = 1'b1;
      tick();
      bus.instrBoundary = 1'b0; bus.irq = '0;
      tick();
      bus.faultIn = 4'b0001; bus.eret = 1'b1;
      #1;
      tests++;
      if ({bus.returnValid, bus.interruptRestore} !== 2'b00) begin fails++; $display("FAIL dfault_noreturn got %b%b want 00", bus.returnValid, bus.interruptRestore); end
      tick();
      bus.faultIn = 4'b0000; bus.eret = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         tests++;
         if ({bus.halted, bus.exceptionPending, bus.vectorValid, bus.interruptDisable, bus.returnValid, bus.interruptRestore} !== 6'b110000) begin
            fails++; $display("FAIL halt_step%0d got %b%b%b%b%b%b want 110000", k, bus.halted, bus.exceptionPending, bus.vectorValid, bus.interruptDisable, bus.returnValid, bus.interruptRestore);
         end
         bus.irq = 16'hFFFF; bus.exceptionMask = 16'hFFFF; bus.instrBoundary = 1'b1; bus.eret = k[0];
         tick();
      end
      drive_idle();
      reset = 1'b1;
      #1;
      tests++;
      if (obs !== 76'h0) begin fails++; $display("FAIL halt_reset got %h want 0", obs); end
      tick();
      reset = 1'b0;
      tick();
      tests++;
      if (obs !== 76'h0) begin fails++; $display("FAIL halt_after_reset got %h want 0", obs); end
   endtask

   // Behavioural model state for the randomized run.
   logic        m_pend, m_entry, m_svc, m_halt, m_sie;
   logic [4:0]  m_cause;
   logic [3:0]  m_lat;
   logic [31:0] m_epc;

   task automatic model_reset();
      m_pend = 0; m_entry = 0; m_svc = 0; m_halt = 0; m_sie = 0;
      m_cause = 0; m_lat = 0; m_epc = 0;
   endtask

   task automatic test_random();
      logic [75:0] exp;
      logic [3:0]  ef;
      logic [15:0] elig;
      logic        rv;
      int          w;
      apply_reset();
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         if (m_halt && $urandom_range(0, 3) == 0) begin
            reset = 1'b1;
            #1;
            model_reset();
            tests++;
            if (obs !== 76'h0) begin fails++; $display("FAIL rand_reset cyc%0d got %h want 0", n, obs); end
            tick();
            reset = 1'b0;
            continue;
         end
         bus.irq             = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0;
         bus.exceptionMask   = 16'($urandom);
         bus.interruptEnable = ($urandom_range(0, 3) != 0);
         bus.isrBaseAddress  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFC0 : 32'($urandom);
         bus.pcIn            = 32'($urandom);
         bus.instrBoundary   = ($urandom_range(0, 2) == 0);
         bus.eret            = ($urandom_range(0, 3) == 0);
         bus.faultIn         = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         #1;
         rv  = m_svc && bus.eret && (bus.faultIn == 4'h0);
         exp = {m_pend | m_entry | m_halt, m_cause, m_entry,
                m_entry ? bus.isrBaseAddress + 32'(m_cause) * 32'd4 : 32'h0,
                m_entry, rv, m_epc, rv, m_sie, m_halt};
         tests++;
         if (obs !== exp) begin fails++; $display("FAIL rand cyc%0d got %h want %h", n, obs, exp); end
         // Winner: lowest pending fault, otherwise lowest eligible IRQ.
         ef   = m_lat | bus.faultIn;
         elig = bus.irq & bus.exceptionMask & {16{bus.interruptEnable}};
         w    = 0;
         for (int j = 0; j < 4; j++) if (ef[j]) begin w = j + 1; break; end
         if (w == 0) for (int i = 0; i < 16; i++) if (elig[i]) begin w = 16 + i; break; end
         m_lat = m_lat | bus.faultIn;
         if (m_halt) begin
         end else if (m_svc) begin
            if (bus.faultIn != 0) begin m_svc = 0; m_halt = 1; end
            else if (bus.eret) m_svc = 0;
         end else if (m_entry) begin
            m_epc = bus.pcIn;
            m_sie = bus.interruptEnable;
            if (m_cause >= 1 && m_cause <= 4) m_lat[m_cause - 1] = bus.faultIn[m_cause - 1];
            m_entry = 0; m_svc = 1;
         end else if (m_pend) begin
            if (m_cause >= 16 && w >= 1 && w <= 4) m_cause = 5'(w);
            if (bus.instrBoundary) begin m_pend = 0; m_entry = 1; end
         end else if (w != 0) begin
            m_cause = 5'(w);
            m_pend  = 1;
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_irq_entry();
      test_masked();
      test_fault_preempt();
      test_dual_fault();
      test_double_fault();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/exception_controller.md
Name: exception_controller

Overview:
- Exception/interrupt sequencer that consumes the system-register state (interruptEnable, exceptionMask, isrBaseAddress).
- Produces exceptionPending and cause back to the system register block.
- Arbitrates synchronous faults and maskable IRQs, handshakes entry with the CPU control unit at instruction boundaries, generates the handler vector, saves the return PC, and sequences return-from-exception.
- A fault raised while a handler is in service halts the core until reset.

Parameters:
- NUM_IRQ, 16, number of maskable interrupt lines; line i is gated by exceptionMask[i].
- NUM_FAULT, 4, number of synchronous fault inputs; fault j maps to cause j+1.
- IRQ_CAUSE_BASE, 16, cause code of irq[0]; irq i uses cause IRQ_CAUSE_BASE+i.

Ports:
- Interface (already decided): reset is asynchronous, active-high; clock is clk.
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- irq  in  NUM_IRQ  level-sensitive interrupt requests
- faultIn  in  NUM_FAULT  single-cycle fault pulses (illegal instr, misaligned, syscall, divide-by-zero)
- interruptEnable  in  1  global IE from system registers
- exceptionMask  in  16  per-line IRQ enable from system registers
- isrBaseAddress  in  32  vector table base
- pcIn  in  32  PC of the instruction at the boundary
- instrBoundary  in  1  CPU is at an instruction boundary and can accept entry
- eret  in  1  single-cycle return-from-exception pulse
- exceptionPending  out  1  entry is committed; the CPU must suppress architectural writes
- cause  out  5  cause code of the current/last exception
- vectorValid  out  1  single-cycle pulse; the CPU loads the PC from vectorAddress
- vectorAddress  out  32  isrBaseAddress + cause*4
- interruptDisable  out  1  pulse, concurrent with vectorValid; the CPU clears IE
- returnValid  out  1  single-cycle pulse on eret; the CPU loads the PC from returnAddress
- returnAddress  out  32  saved PC (epc)
- interruptRestore  out  1  pulse, concurrent with returnValid
- restoreValue  out  1  IE value saved at entry; write back to IE when interruptRestore is high
- halted  out  1  double fault; sticky until reset

Behaviour:
- Reset values: all outputs 0; state IDLE, fault latch 0, epc 0, savedIe 0.
- Fault latch: faultIn bits OR into a sticky latch every cycle. A latched bit clears only in the ENTRY cycle that services it.
- Eligible IRQ i: irq[i] && exceptionMask[i] && interruptEnable.
- Priority: any latched fault beats any IRQ. Among faults, the lowest j wins; among IRQs, the lowest i wins.
- IDLE:
  - If any latched fault or eligible IRQ exists, register the winning cause and go to PENDING next cycle.
  - Detection-to-exceptionPending latency is 1 cycle.
- PENDING:
  - exceptionPending=1.
  - If the current cause is an IRQ and a fault becomes latched, cause is replaced by the fault's cause.
  - An IRQ deasserting after commit does not cancel entry.
  - On instrBoundary=1, go to ENTRY.
- ENTRY (exactly one cycle):
  - exceptionPending=1, vectorValid=1, interruptDisable=1.
  - vectorAddress = isrBaseAddress + {cause,2'b00}; 32-bit wraparound, carry discarded.
  - Registered at end of cycle: epc <= pcIn, savedIe <= interruptEnable, latch bit of a serviced fault cleared.
  - Next state SERVICE.
- SERVICE:
  - IRQs are ignored.
  - On eret: returnValid=1, interruptRestore=1, returnAddress=epc, restoreValue=savedIe that cycle; then go to IDLE.
  - A new fault pulse while in SERVICE (including the eret cycle) goes to HALT; HALT wins over eret.
- HALT: halted=1, exceptionPending=1, all pulse outputs 0. Leaves only via reset.
- eret outside SERVICE is ignored.
- cause holds its value after return until the next commit.
- Reset mid-sequence aborts immediately to IDLE with all outputs 0; latched faults are discarded.
- returnAddress is driven continuously from epc.
- vectorAddress is combinational from the registered cause and is valid only while vectorValid=1.

Decomposition:
- Package exceptionGroup: state enum (IDLE, PENDING, ENTRY, SERVICE, HALT), and cause constants CAUSE_NONE=0, CAUSE_ILLEGAL=1, CAUSE_MISALIGN=2, CAUSE_SYSCALL=3, CAUSE_DIVZERO=4, CAUSE_IRQ_BASE=16.
- One sub-module, exception_priority_encoder: combinational arbitration over the fault latch and eligible IRQs, returning a valid bit and a 5-bit cause.

Test Plan:
- irq[3]=1, mask[3]=1, IE=1, isrBase=0x1000, instrBoundary held 0 for 3 cycles then 1, pcIn=0x200 -> exceptionPending rises 1 cycle after irq; vectorValid pulses with vectorAddress=0x104C (cause 19); epc=0x200; interruptDisable pulses.
- irq[5] asserted with mask[5]=0, or with IE=0 -> no pending, state stays IDLE, cause stays 0.
- irq[2] committed (PENDING), then faultIn[1] pulse before boundary -> cause becomes 2, vectorAddress=isrBase+8; fault latch bit 1 cleared after ENTRY.
- Simultaneous faultIn[2] and faultIn[0] -> cause 1 serviced first; after eret, cause 3 is taken with no new pulse.
- In SERVICE with savedIe=1, eret pulse -> returnValid=1, returnAddress=epc, interruptRestore=1, restoreValue=1, state IDLE.
- In SERVICE, faultIn[0] pulse together with eret -> halted=1, no returnValid; irq activity is then ignored; reset clears halted and all outputs to 0.
